muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- Consumes the same instruction fields the ALU control path decodes (funct3, with funct7 = 0000001 already qualified upstream) and both register operands.
- Produces one XLEN result per accepted op through a valid/ready handshake. The pipeline stalls on start_ready/result_valid.
- One radix-2 step per cycle: shift-add multiply, restoring divide.

Parameters:
- XLEN, 32, operand/result width. Must be even and >= 8.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  op request
- start_ready  out  1  unit can accept; equals (state == IDLE)
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  XLEN  operand A (dividend / multiplicand)
- rs2  in  XLEN  operand B (divisor / multiplier)
- kill  in  1  synchronous flush from branch/exception
- result  out  XLEN  registered result
- result_valid  out  1  result holds a completed op
- result_ready  in  1  consumer takes the result

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE, counter = 0, result = 0, result_valid = 0.
  - All operand/accumulator registers are cleared.
  - start_ready reads 1 during and after reset.
  - An in-flight op is discarded with no output.
- States: IDLE, CALC, SIGN, DONE.
- Accept: start_valid && start_ready && !kill at a rising edge.
  - Latch funct3, sign flags and operand magnitudes.
  - Signed operands: DIV/REM/MULH take |rs1|, |rs2|. MULHSU takes |rs1| only.
  - Clear counter and the 2*XLEN accumulator, then go to CALC.
- Special-case bypass at the accept edge (go directly to DONE; result_valid visible 1 edge after accept):
  - Divide by zero (rs2 == 0): DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow (DIV/REM, rs1 == 100..0, rs2 == all ones): DIV -> rs1; REM -> 0.
- CALC:
  - One iteration per edge; counter increments.
  - Multiply: if multiplier LSB is set, add the multiplicand into the upper half; then shift the {acc} right by 1.
  - Divide: shift {rem, quo} left by 1; trial-subtract the divisor from rem; if there is no borrow, keep the difference and set the quotient LSB.
  - After exactly XLEN iterations (counter == XLEN-1 at the edge), go to SIGN.
- SIGN: one cycle. Apply the sign and select the result, then go to DONE with result_valid = 1.
  - Product is negated if the operand signs differ (MULHSU: sign of rs1 only).
  - Quotient is negated if signs differ; remainder takes the sign of the dividend.
  - Result selection: MUL -> low XLEN; MULH/MULHSU/MULHU -> high XLEN; DIV/DIVU -> quotient; REM/REMU -> remainder.
- Latency: result_valid rises exactly XLEN+2 edges after the accept edge. That is 34 for XLEN=32: accept, 32 CALC steps, SIGN.
- DONE:
  - result and result_valid hold stable until result_ready is high at an edge.
  - Then result_valid = 0, state = IDLE.
  - No new op is accepted in the same edge; issue throughput is 1 op per XLEN+3 cycles minimum.
- kill:
  - Highest synchronous priority.
  - From any state, go to IDLE and set result_valid = 0 at that edge.
  - A start_valid in a kill cycle is not accepted.
  - kill in DONE drops the unconsumed result.
- Input stability: rs1/rs2/funct3 are only sampled at the accept edge; changes afterwards have no effect.
- Width rules: all arithmetic is unsigned on magnitudes, using an XLEN+1-bit subtractor. Two's-complement negation is applied only in SIGN. No state is left undefined; unused counter values return to IDLE.

Test Plan:
- MUL, rs1=7, rs2=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB. result_valid rises exactly 34 edges after accept. MULH with the same operands -> 0xFFFFFFFF. MULHU -> 0x00000006.
- DIV rs1=-20, rs2=6 -> 0xFFFFFFFD (-3). REM -> 0xFFFFFFFE (-2). DIVU 20/6 -> 3. REMU -> 2.
- DIV by zero, rs1=0x12345678 -> 0xFFFFFFFF after 1 edge. REMU by zero -> 0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Backpressure: hold result_ready=0 for 10 cycles in DONE. result stays stable and start_ready=0 throughout. Pulse result_ready -> IDLE next edge, start_ready=1.
- kill asserted at CALC step 15 with start_valid=1 in the same cycle -> IDLE, no result_valid, request not accepted. Re-issue MULHSU rs1=-1, rs2=2 -> 0xFFFFFFFF.
- rst_n pulled low asynchronously mid-CALC (not at a clock edge) -> result=0, result_valid=0, start_ready=1 immediately. After release, MUL 0x10000 x 0x10000 -> low 0x00000000, MULHU -> 0x00000001.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle (shift-add multiply,
// restoring divide) on operand magnitudes, with sign fix-up in a single final cycle.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  input  logic            result_ready
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                result_valid_q, result_valid_d;

  logic                accept, div_zero, div_ovf, bypass, last_step;
  logic                sa, sb;
  logic [XLEN:0]       mul_sum, div_r1, div_diff;
  logic                div_borrow;
  logic [XLEN-1:0]     div_rem;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_s, rem_s;

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic s);
    return s ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic [2*XLEN-1:0] v, input logic s);
    return s ? (~v + 1'b1) : v;
  endfunction

  assign accept    = start_valid && (state_q == IDLE) && !kill;
  assign div_zero  = funct3[2] && (rs2 == '0);
  assign div_ovf   = funct3[2] && !funct3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
  assign bypass    = div_zero || div_ovf;
  assign last_step = (cnt_q == CNT_W'(XLEN-1));

  // One iteration: multiplier LSB gates the add; divisor trial-subtract on {rem, next dividend bit}
  assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (opb_q[0] ? opa_q : '0)};
  assign div_r1     = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]};
  assign div_diff   = div_r1 - {1'b0, opb_q};
  assign div_borrow = div_diff[XLEN];
  assign div_rem    = div_borrow ? div_r1[XLEN-1:0] : div_diff[XLEN-1:0];

  assign prod_s = cneg2(acc_q, neg_q);
  assign quo_s  = cneg(acc_q[XLEN-1:0], neg_q);
  assign rem_s  = cneg(acc_q[2*XLEN-1:XLEN], rneg_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      op_q           <= '0;
      neg_q          <= 1'b0;
      rneg_q         <= 1'b0;
      opa_q          <= '0;
      opb_q          <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      neg_q          <= neg_d;
      rneg_q         <= rneg_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_valid) state_d = bypass ? DONE : CALC;
        CALC:    if (last_step) state_d = SIGN;
        SIGN:    state_d = DONE;
        DONE:    if (result_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d          = cnt_q;
    op_d           = op_q;
    neg_d          = neg_q;
    rneg_d         = rneg_q;
    opa_d          = opa_q;
    opb_d          = opb_q;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    sa             = 1'b0;
    sb             = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (funct3)
            3'b001, 3'b100, 3'b110: begin sa = rs1[XLEN-1]; sb = rs2[XLEN-1]; end
            3'b010:                 sa = rs1[XLEN-1];
            default:                ;
          endcase
          op_d   = funct3;
          opa_d  = cneg(rs1, sa);
          opb_d  = cneg(rs2, sb);
          neg_d  = sa ^ sb;
          rneg_d = sa;
          acc_d  = '0;
          cnt_d  = '0;
          if (bypass) begin
            result_valid_d = 1'b1;
            if (div_zero) result_d = funct3[1] ? rs1 : '1;
            else          result_d = funct3[1] ? '0 : rs1;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[2]) begin
          acc_d = {div_rem, acc_q[XLEN-2:0], ~div_borrow};
          opa_d = opa_q << 1;
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
          opb_d = opb_q >> 1;
        end
      end
      SIGN: begin
        result_valid_d = 1'b1;
        case (op_q)
          3'b000:                 result_d = prod_s[XLEN-1:0];
          3'b001, 3'b010, 3'b011: result_d = prod_s[2*XLEN-1:XLEN];
          3'b100, 3'b101:         result_d = quo_s;
          default:                result_d = rem_s;
        endcase
      end
      DONE:    if (result_ready) result_valid_d = 1'b0;
      default: ;
    endcase
    if (kill) result_valid_d = 1'b0;
  end

  always_comb begin
    start_ready  = (state_q == IDLE);
    result       = result_q;
    result_valid = result_valid_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: result values, latency, backpressure, kill and async reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        kill;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;

  int n_chk  = 0;
  int n_pass = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .kill(kill), .result(result),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Called at posedge+1; returns at accept edge+1 with operands scrambled.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    funct3 = f; rs1 = a; rs2 = b; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
  endtask

  // Edges counted including the accept edge.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!result_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk({tag, "_rdy"}, {31'd0, start_ready}, 32'd1);
    chk({tag, "_vld"}, {31'd0, result_valid}, 32'd0);
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  vec_t vecs[11] = '{
    '{"mul",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34},
    '{"mulh",    3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 34},
    '{"mulhu",   3'b011, 32'd7,        32'hFFFFFFFD, 32'h00000006, 34},
    '{"div",     3'b100, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 34},
    '{"rem",     3'b110, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 34},
    '{"divu",    3'b101, 32'd20,       32'd6,        32'd3,        34},
    '{"remu",    3'b111, 32'd20,       32'd6,        32'd2,        34},
    '{"div0",    3'b100, 32'h12345678, 32'd0,        32'hFFFFFFFF, 1},
    '{"remu0",   3'b111, 32'h12345678, 32'd0,        32'h12345678, 1},
    '{"div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
    '{"rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1}
  };

  initial begin
    int lat;
    int bad;
    logic [31:0] held;

    rst_n = 1'b0; start_valid = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    kill = 1'b0; result_ready = 1'b0;
    #12;
    chk("rst_result", result, 32'd0);
    chk("rst_vld", {31'd0, result_valid}, 32'd0);
    chk("rst_rdy", {31'd0, start_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      chk({vecs[i].tag, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      chk(vecs[i].tag, result, vecs[i].exp);
      consume(vecs[i].tag);
    end

    // Backpressure: result held for 10 cycles with result_ready low
    issue(3'b000, 32'd7, 32'hFFFFFFFD);
    wait_valid(lat);
    held = result;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (result !== held || start_ready !== 1'b0 || result_valid !== 1'b1) bad++;
    end
    chk("bp_stable", 32'(bad), 32'd0);
    chk("bp_result", held, 32'hFFFFFFEB);
    consume("bp");

    // kill at CALC step 15 together with a new request
    issue(3'b000, 32'd7, 32'd9);
    repeat (14) begin @(posedge clk); #1; end
    kill = 1'b1; start_valid = 1'b1; funct3 = 3'b011; rs1 = 32'd5; rs2 = 32'd5;
    @(posedge clk); #1;
    kill = 1'b0; start_valid = 1'b0;
    chk("kill_rdy", {31'd0, start_ready}, 32'd1);
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (result_valid !== 1'b0 || start_ready !== 1'b1) bad++;
    end
    chk("kill_quiet", 32'(bad), 32'd0);
    issue(3'b010, 32'hFFFFFFFF, 32'd2);
    wait_valid(lat);
    chk("mulhsu_lat", 32'(lat), 32'd34);
    chk("mulhsu", result, 32'hFFFFFFFF);

    // kill in DONE drops the unconsumed result
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_done_vld", {31'd0, result_valid}, 32'd0);
    chk("kill_done_rdy", {31'd0, start_ready}, 32'd1);

    // Asynchronous reset mid-CALC, away from a clock edge
    issue(3'b011, 32'd3, 32'd5);
    repeat (10) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_result", result, 32'd0);
    chk("arst_vld", {31'd0, result_valid}, 32'd0);
    chk("arst_rdy", {31'd0, start_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    issue(3'b000, 32'h00010000, 32'h00010000);
    wait_valid(lat);
    chk("mul_big_lat", 32'(lat), 32'd34);
    chk("mul_big", result, 32'h00000000);
    consume("mul_big");
    issue(3'b011, 32'h00010000, 32'h00010000);
    wait_valid(lat);
    chk("mulhu_big", result, 32'h00000001);
    consume("mulhu_big");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
